tank_cycle_controller: RTL and testbench

- Sequences one tank treatment cycle: fill, dosing window, mix, drain, clean.
- Drives the 2-bit `state` code consumed by the pesticide verification block. In that code, 01 is the only code in which pesticide may be added, and 10 clears the pesticide flag.
- Uses sensor inputs and the verification block's `alert_on` flag to advance.
- Per-phase timers bound every wait.

---
 rtl/tank_cycle_controller_pkg.sv | 22 ++
 rtl/tank_cycle_controller_timer.sv | 34 +++
 rtl/tank_cycle_controller.sv | 159 +++++++++++++++
 tb/tb_tank_cycle_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tank_cycle_controller_pkg.sv
// Shared definitions for the tank treatment cycle controller and the pesticide
// verification block that consumes its phase code.
package tank_cycle_controller_pkg;

    typedef enum logic [2:0] {
        FSM_IDLE  = 3'b000,
        FSM_FILL  = 3'b001,
        FSM_DOSE  = 3'b010,
        FSM_MIX   = 3'b011,
        FSM_DRAIN = 3'b100,
        FSM_CLEAN = 3'b101,
        FSM_FAULT = 3'b110
    } fsm_e;

    // Phase codes seen by the verification block: only ST_DOSE permits pesticide,
    // ST_CLEAN clears its pesticide flag.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_DOSE  = 2'b01;
    localparam logic [1:0] ST_CLEAN = 2'b10;
    localparam logic [1:0] ST_BUSY  = 2'b11;

endpackage

// File: rtl/tank_cycle_controller_timer.sv
// Phase timer: counts cycles spent in the current phase, cleared on every phase
// change and saturating at all-ones so a stuck phase can never wrap.
module phase_timer #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (count_q != '1) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tank_cycle_controller.sv
// Tank treatment cycle sequencer: fill, dosing window, mix, drain, clean, with
// per-phase timeouts and a FAULT state that needs an explicit clear.
module tank_cycle_controller
    import tank_cycle_controller_pkg::*;
#(
    parameter int unsigned CNT_W        = 24,
    parameter int unsigned FILL_MAX     = 1000,
    parameter int unsigned DOSE_MAX     = 5000,
    parameter int unsigned MIX_CYCLES   = 2000,
    parameter int unsigned DRAIN_MAX    = 1000,
    parameter int unsigned CLEAN_CYCLES = 500
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       start,
    input  logic       abort,
    input  logic       fault_clr,
    input  logic       tank_full,
    input  logic       tank_empty,
    input  logic       alert_on,
    output logic [1:0] state,
    output logic       valve_in,
    output logic       valve_out,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic       dosed
);

    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_MAX - 1);
    localparam logic [CNT_W-1:0] DOSE_LAST  = CNT_W'(DOSE_MAX - 1);
    localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);
    localparam logic [CNT_W-1:0] CLEAN_LAST = CNT_W'(CLEAN_CYCLES - 1);

    fsm_e             fsm_q, fsm_d;
    logic             start_q;
    logic             start_armed_q, start_armed_d;
    logic             dosed_q, dosed_d;
    logic             done_q, done_d;
    logic             timer_clr;
    logic [CNT_W-1:0] timer;
    logic             start_p;

    // A start level already high when reset releases must go low once before it
    // can trigger, so the edge detector is only armed after a low sample.
    assign start_armed_d = start_armed_q | ~start;
    assign start_p       = start & ~start_q & start_armed_q;
    assign timer_clr     = (fsm_d != fsm_q);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .init_n (init_n),
        .clr    (timer_clr),
        .count  (timer)
    );

    always_comb begin
        fsm_d   = fsm_q;
        dosed_d = dosed_q;
        done_d  = 1'b0;
        case (fsm_q)
            FSM_IDLE: begin
                if (start_p) begin
                    fsm_d   = FSM_FILL;
                    dosed_d = 1'b0;
                end
            end
            FSM_FILL: begin
                if (abort)                   fsm_d = FSM_DRAIN;
                else if (tank_full)          fsm_d = FSM_DOSE;
                else if (timer == FILL_LAST) fsm_d = FSM_FAULT;
            end
            FSM_DOSE: begin
                if (abort) begin
                    fsm_d = FSM_DRAIN;
                end else if (alert_on) begin
                    fsm_d   = FSM_MIX;
                    dosed_d = 1'b1;
                end else if (timer == DOSE_LAST) begin
                    fsm_d   = FSM_DRAIN;
                    dosed_d = 1'b0;
                end
            end
            FSM_MIX: begin
                if (abort || timer == MIX_LAST) fsm_d = FSM_DRAIN;
            end
            FSM_DRAIN: begin
                if (tank_empty)               fsm_d = FSM_CLEAN;
                else if (timer == DRAIN_LAST) fsm_d = FSM_FAULT;
            end
            FSM_CLEAN: begin
                if (timer == CLEAN_LAST) begin
                    fsm_d  = FSM_IDLE;
                    done_d = 1'b1;
                end
            end
            FSM_FAULT: begin
                if (fault_clr) fsm_d = FSM_IDLE;
            end
            default: fsm_d = FSM_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            fsm_q         <= FSM_IDLE;
            start_q       <= 1'b0;
            start_armed_q <= 1'b0;
            dosed_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            start_q       <= start;
            start_armed_q <= start_armed_d;
            dosed_q       <= dosed_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state     = ST_IDLE;
        valve_in  = 1'b0;
        valve_out = 1'b0;
        busy      = 1'b0;
        fault     = 1'b0;
        case (fsm_q)
            FSM_FILL: begin
                valve_in = 1'b1;
                busy     = 1'b1;
            end
            FSM_DOSE: begin
                state = ST_DOSE;
                busy  = 1'b1;
            end
            FSM_MIX: begin
                state = ST_BUSY;
                busy  = 1'b1;
            end
            FSM_DRAIN: begin
                state     = ST_BUSY;
                valve_out = 1'b1;
                busy      = 1'b1;
            end
            FSM_CLEAN: begin
                state     = ST_CLEAN;
                valve_in  = 1'b1;
                valve_out = 1'b1;
                busy      = 1'b1;
            end
            FSM_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    assign done  = done_q;
    assign dosed = dosed_q;

endmodule

// File: tb/tb_tank_cycle_controller.sv
// Directed bench for tank_cycle_controller: a vector table for the nominal cycle
// plus hand-written sequences for timeouts, aborts, simultaneous events and reset.
module tb_tank_cycle_controller;

    // Input vector bits: {start, abort, fault_clr, tank_full, tank_empty, alert_on}
    localparam logic [5:0] IN_NONE = 6'b000000;
    localparam logic [5:0] START   = 6'b100000;
    localparam logic [5:0] ABORT   = 6'b010000;
    localparam logic [5:0] FCLR    = 6'b001000;
    localparam logic [5:0] FULL    = 6'b000100;
    localparam logic [5:0] EMPTY   = 6'b000010;
    localparam logic [5:0] ALERT   = 6'b000001;

    // Output bits: {state[1:0], valve_in, valve_out, busy, done, fault, dosed}
    localparam logic [7:0] O_IDLE  = 8'b00_0_0_0_0_0_0;
    localparam logic [7:0] O_FILL  = 8'b00_1_0_1_0_0_0;
    localparam logic [7:0] O_DOSE  = 8'b01_0_0_1_0_0_0;
    localparam logic [7:0] O_MIX   = 8'b11_0_0_1_0_0_0;
    localparam logic [7:0] O_DRAIN = 8'b11_0_1_1_0_0_0;
    localparam logic [7:0] O_CLEAN = 8'b10_1_1_1_0_0_0;
    localparam logic [7:0] O_FAULT = 8'b00_0_0_0_0_1_0;
    localparam logic [7:0] DONE    = 8'b00_0_0_0_1_0_0;
    localparam logic [7:0] DOSED   = 8'b00_0_0_0_0_0_1;

    typedef struct {
        logic [5:0] in;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       init_n;
    logic       start, abort, fault_clr, tank_full, tank_empty, alert_on;
    logic [1:0] state;
    logic       valve_in, valve_out, busy, done, fault, dosed;

    int testsRun = 0;
    int testsFailed = 0;
    vec_t tbl[20];

    tank_cycle_controller #(
        .CNT_W        (24),
        .FILL_MAX     (8),
        .DOSE_MAX     (6),
        .MIX_CYCLES   (4),
        .DRAIN_MAX    (8),
        .CLEAN_CYCLES (3)
    ) dut (
        .clk        (clk),
        .init_n     (init_n),
        .start      (start),
        .abort      (abort),
        .fault_clr  (fault_clr),
        .tank_full  (tank_full),
        .tank_empty (tank_empty),
        .alert_on   (alert_on),
        .state      (state),
        .valve_in   (valve_in),
        .valve_out  (valve_out),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .dosed      (dosed)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and land 1 time unit after the sampling edge.
    task automatic applyStimulus(input logic [5:0] inVec);
        {start, abort, fault_clr, tank_full, tank_empty, alert_on} = inVec;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expVal);
        logic [7:0] got;
        got = {state, valve_in, valve_out, busy, done, fault, dosed};
        testsRun++;
        if (got !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b expected %b (state,vi,vo,busy,done,fault,dosed)",
                     name, got, expVal);
        end
    endtask

    task automatic stepCheck(input string name, input logic [5:0] inVec, input logic [7:0] expVal);
        applyStimulus(inVec);
        checkOutput(name, expVal);
    endtask

    initial begin
        // Nominal cycle with start held high throughout to show it never retriggers.
        tbl[0] = '{START, O_FILL};
        tbl[1] = '{START, O_FILL};
        tbl[2] = '{START, O_FILL};
        tbl[3] = '{START | FULL, O_DOSE};
        tbl[4] = '{START, O_DOSE};
        for (int i = 5; i <= 8; i++)  tbl[i] = '{START | ALERT, O_MIX | DOSED};
        for (int i = 9; i <= 13; i++) tbl[i] = '{START | ALERT, O_DRAIN | DOSED};
        tbl[14] = '{START | ALERT | EMPTY, O_CLEAN | DOSED};
        tbl[15] = '{START, O_CLEAN | DOSED};
        tbl[16] = '{START, O_CLEAN | DOSED};
        tbl[17] = '{START, O_IDLE | DONE | DOSED};
        tbl[18] = '{START, O_IDLE | DOSED};
        tbl[19] = '{IN_NONE, O_IDLE | DOSED};

        {start, abort, fault_clr, tank_full, tank_empty, alert_on} = IN_NONE;
        init_n = 1'b0;
        #12;
        checkOutput("reset", O_IDLE);
        init_n = 1'b1;
        stepCheck("idle_after_reset", IN_NONE, O_IDLE);

        for (int i = 0; i < 20; i++) begin
            stepCheck($sformatf("nominal[%0d]", i), tbl[i].in, tbl[i].exp);
        end

        // No dose: DOSE times out after 6 cycles, cycle still completes.
        stepCheck("nodose_fill", START, O_FILL);
        stepCheck("nodose_dose0", START | FULL, O_DOSE);
        for (int i = 1; i < 6; i++) stepCheck($sformatf("nodose_dose%0d", i), START, O_DOSE);
        stepCheck("nodose_drain", START, O_DRAIN);
        stepCheck("nodose_clean0", EMPTY, O_CLEAN);
        stepCheck("nodose_clean1", IN_NONE, O_CLEAN);
        stepCheck("nodose_clean2", IN_NONE, O_CLEAN);
        stepCheck("nodose_done", IN_NONE, O_IDLE | DONE);

        // Fill timeout, start ignored in FAULT, fault_clr returns to IDLE.
        stepCheck("filltmo_fill0", START, O_FILL);
        for (int i = 1; i < 8; i++) stepCheck($sformatf("filltmo_fill%0d", i), START, O_FILL);
        stepCheck("filltmo_fault", START, O_FAULT);
        stepCheck("fault_start_low", IN_NONE, O_FAULT);
        stepCheck("fault_start_edge", START, O_FAULT);
        stepCheck("fault_abort", ABORT, O_FAULT);
        stepCheck("fault_clr", START | FCLR, O_IDLE);
        stepCheck("idle_after_clr", IN_NONE, O_IDLE);

        // Abort in MIX, then abort held in CLEAN has no effect.
        stepCheck("abort_fill", START, O_FILL);
        stepCheck("abort_dose", START | FULL, O_DOSE);
        stepCheck("abort_mix0", ALERT, O_MIX | DOSED);
        stepCheck("abort_mix1", ALERT, O_MIX | DOSED);
        stepCheck("abort_to_drain", ABORT, O_DRAIN | DOSED);
        stepCheck("abort_clean0", ABORT | EMPTY, O_CLEAN | DOSED);
        stepCheck("abort_clean1", ABORT, O_CLEAN | DOSED);
        stepCheck("abort_clean2", ABORT, O_CLEAN | DOSED);
        stepCheck("abort_clean_done", ABORT, O_IDLE | DONE | DOSED);

        // Simultaneous events: sensor wins over timeout; alert already high on DOSE entry.
        stepCheck("sim_fill0", START, O_FILL);
        for (int i = 1; i < 8; i++) stepCheck($sformatf("sim_fill%0d", i), START, O_FILL);
        stepCheck("sim_full_on_expiry", START | FULL | ALERT, O_DOSE);
        stepCheck("sim_alert_preset", START | ALERT, O_MIX | DOSED);
        stepCheck("sim_mix_abort", ABORT, O_DRAIN | DOSED);
        for (int i = 1; i < 8; i++) stepCheck($sformatf("sim_drain%0d", i), IN_NONE, O_DRAIN | DOSED);
        stepCheck("sim_empty_on_expiry", EMPTY, O_CLEAN | DOSED);
        stepCheck("sim_clean1", IN_NONE, O_CLEAN | DOSED);
        stepCheck("sim_clean2", IN_NONE, O_CLEAN | DOSED);
        stepCheck("sim_done", IN_NONE, O_IDLE | DONE | DOSED);

        // Abort in FILL goes to DRAIN; asynchronous reset mid-DRAIN.
        stepCheck("rst_fill", START, O_FILL);
        stepCheck("rst_abort_fill", START | ABORT, O_DRAIN);
        stepCheck("rst_drain", START, O_DRAIN);
        #2;
        init_n = 1'b0;
        #1;
        checkOutput("async_reset_immediate", O_IDLE);
        #3;
        init_n = 1'b1;
        stepCheck("start_held_after_reset0", START, O_IDLE);
        stepCheck("start_held_after_reset1", START, O_IDLE);
        stepCheck("start_low_after_reset", IN_NONE, O_IDLE);
        stepCheck("start_edge_after_reset", START, O_FILL);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
